// File: rtl/delay_unit_pkg.sv
// Shared types and defaults for the delay_unit_sink block and its lanes.
package delay_unit_pkg;

  localparam int unsigned WidthDefault = 5;
  localparam int unsigned DelayDefault = 3;
  localparam int unsigned CntWDefault  = 8;
  // Wide enough for the largest legal DELAY-1 (14).
  localparam int unsigned DlyCntW      = 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWait   = 2'd1,
    StAccept = 2'd2
  } state_e;

  function automatic logic [DlyCntW-1:0] dly_last(input int unsigned delay);
    return DlyCntW'(delay - 1);
  endfunction

endpackage

// File: rtl/delay_unit_sink_if.sv
// One valid/ready lane: the producer drives data/valid, the sink drives ready.
interface delay_unit_sink_if
  import delay_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault
) ();

  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/delay_unit_sink_lane.sv
// One sink lane: waits DELAY cycles after sampling valid, then accepts one beat
// and keeps running statistics of what it accepted.
module delay_unit_sink_lane
  import delay_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned DELAY = DelayDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic [WIDTH-1:0] last,
  output logic [CNT_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [DlyCntW-1:0] CntLast = dly_last(DELAY);

  state_e             state_q, state_d;
  logic [DlyCntW-1:0] cnt_q, cnt_d;
  logic               ready_q;
  logic [WIDTH-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               err_q, err_d;
  logic               xfer;
  logic               viol;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    viol    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (valid) begin
          if (DELAY == 1) begin
            state_d = StAccept;
          end else begin
            state_d = StWait;
            cnt_d   = DlyCntW'(1);
          end
        end
      end
      StWait: begin
        if (!valid) begin
          // Producer withdrew before we were ready.
          viol    = 1'b1;
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StAccept;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + DlyCntW'(1);
        end
      end
      StAccept: begin
        state_d = StIdle;
        if (valid) xfer = 1'b1;
        else       viol = 1'b1;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // clr wins over accumulated history but still records this cycle's events.
  always_comb begin
    last_d  = xfer ? data : last_q;
    err_d   = clr ? viol : (err_q | viol);
    sum_d   = sum_q;
    count_d = count_q;
    if (clr) begin
      sum_d   = xfer ? CNT_W'(data) : '0;
      count_d = xfer ? CNT_W'(1) : '0;
    end else if (xfer) begin
      sum_d   = sum_q + CNT_W'(data);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      last_q  <= '0;
      sum_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StAccept);
      last_q  <= last_d;
      sum_q   <= sum_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign ready = ready_q;
  assign last  = last_q;
  assign sum   = sum_q;
  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/delay_unit_sink.sv
// Two-lane delayed-ready sink; each lane runs independently of the other.
module delay_unit_sink
  import delay_unit_pkg::*;
#(
  parameter int unsigned WIDTH = WidthDefault,
  parameter int unsigned DELAY = DelayDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  delay_unit_sink_if.slave I_0,
  delay_unit_sink_if.slave I_1,
  input  logic             clr,
  output logic [WIDTH-1:0] last_0,
  output logic [WIDTH-1:0] last_1,
  output logic [CNT_W-1:0] sum_0,
  output logic [CNT_W-1:0] sum_1,
  output logic [CNT_W-1:0] count_0,
  output logic [CNT_W-1:0] count_1,
  output logic             err_0,
  output logic             err_1
);

  delay_unit_sink_lane #(
    .WIDTH (WIDTH),
    .DELAY (DELAY),
    .CNT_W (CNT_W)
  ) u_lane_0 (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .clr   (clr),
    .data  (I_0.data),
    .valid (I_0.valid),
    .ready (I_0.ready),
    .last  (last_0),
    .sum   (sum_0),
    .count (count_0),
    .err   (err_0)
  );

  delay_unit_sink_lane #(
    .WIDTH (WIDTH),
    .DELAY (DELAY),
    .CNT_W (CNT_W)
  ) u_lane_1 (
    .clk   (CLK),
    .rst_n (ASYNCRESETN),
    .clr   (clr),
    .data  (I_1.data),
    .valid (I_1.valid),
    .ready (I_1.ready),
    .last  (last_1),
    .sum   (sum_1),
    .count (count_1),
    .err   (err_1)
  );

endmodule

// File: tb/tb_delay_unit_sink.sv
// Bench for delay_unit_sink: directed scenarios then random traffic, all
// checked against a cycle-stamp reference model of each lane.
module tb_delay_unit_sink;

  localparam int unsigned W   = 5;
  localparam int unsigned D   = 3;
  localparam int unsigned CW  = 8;
  localparam int unsigned MOD = 1 << CW;

  logic          CLK = 1'b0;
  logic          ASYNCRESETN;
  logic          clr;
  logic [W-1:0]  last_0, last_1;
  logic [CW-1:0] sum_0, sum_1, count_0, count_1;
  logic          err_0, err_1;

  always #5 CLK = ~CLK;

  delay_unit_sink_if #(.WIDTH(W)) i0 ();
  delay_unit_sink_if #(.WIDTH(W)) i1 ();

  delay_unit_sink #(
    .WIDTH (W),
    .DELAY (D),
    .CNT_W (CW)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I_0         (i0),
    .I_1         (i1),
    .clr         (clr),
    .last_0      (last_0),
    .last_1      (last_1),
    .sum_0       (sum_0),
    .sum_1       (sum_1),
    .count_0     (count_0),
    .count_1     (count_1),
    .err_0       (err_0),
    .err_1       (err_1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: a lane is either idle (start < 0) or inside a window opened at
  // cycle 'start'; ready is due exactly at start + D, and valid must stay high.
  int          m_start[2];
  int unsigned m_sum[2], m_cnt[2], m_last[2];
  bit          m_err[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_start[l] = -1;
      m_sum[l]   = 0;
      m_cnt[l]   = 0;
      m_last[l]  = 0;
      m_err[l]   = 1'b0;
    end
  endtask

  function automatic bit exp_ready(input int l);
    return (m_start[l] >= 0) && (cyc == m_start[l] + int'(D));
  endfunction

  task automatic model_edge(input int l, input bit v, input int unsigned d, input bit c);
    bit xfer = 1'b0;
    bit viol = 1'b0;
    if (m_start[l] < 0) begin
      if (v) m_start[l] = cyc;
    end else if (cyc == m_start[l] + int'(D)) begin
      if (v) xfer = 1'b1;
      else   viol = 1'b1;
      m_start[l] = -1;
    end else if (!v) begin
      viol       = 1'b1;
      m_start[l] = -1;
    end
    if (c) begin
      m_sum[l] = 0;
      m_cnt[l] = 0;
      m_err[l] = 1'b0;
    end
    if (xfer) begin
      m_sum[l]  = (m_sum[l] + d) % MOD;
      m_cnt[l]  = (m_cnt[l] + 1) % MOD;
      m_last[l] = d;
    end
    if (viol) m_err[l] = 1'b1;
  endtask

  task automatic check_stats();
    check("last0", 32'(last_0), m_last[0]);
    check("sum0", 32'(sum_0), m_sum[0]);
    check("count0", 32'(count_0), m_cnt[0]);
    check("err0", 32'(err_0), 32'(m_err[0]));
    check("last1", 32'(last_1), m_last[1]);
    check("sum1", 32'(sum_1), m_sum[1]);
    check("count1", 32'(count_1), m_cnt[1]);
    check("err1", 32'(err_1), 32'(m_err[1]));
  endtask

  // Check this cycle's ready, advance model and DUT one edge, check stats.
  task automatic step();
    check("ready0", 32'(i0.ready), 32'(exp_ready(0)));
    check("ready1", 32'(i1.ready), 32'(exp_ready(1)));
    model_edge(0, i0.valid, i0.data, clr);
    model_edge(1, i1.valid, i1.data, clr);
    @(posedge CLK);
    #1;
    cyc++;
    check_stats();
  endtask

  task automatic drive(input bit v0, input int unsigned d0, input bit v1, input int unsigned d1);
    i0.valid = v0;
    i0.data  = W'(d0);
    i1.valid = v1;
    i1.data  = W'(d1);
  endtask

  task automatic xfer0(input int unsigned d);
    drive(1'b1, d, 1'b0, 0);
    repeat (D + 1) step();
    drive(1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    ASYNCRESETN = 1'b0;
    clr         = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    model_reset();
    #12;
    check("rst_ready0", 32'(i0.ready), 0);
    check("rst_ready1", 32'(i1.ready), 0);
    check_stats();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    @(posedge CLK);
    #1;
    cyc = 0;

    // Single delayed transfer on lane 0: valid at cycle 10, ready at 13.
    repeat (10) step();
    drive(1'b1, 'h0A, 1'b0, 0);
    repeat (D) step();
    check("r030_ready", 32'(i0.ready), 1);
    step();
    drive(1'b0, 0, 1'b0, 0);
    step();
    check("r030_last", 32'(last_0), 'h0A);
    check("r030_sum", 32'(sum_0), 10);
    check("r030_count", 32'(count_0), 1);

    // Lane 1 held valid for 40 cycles: one transfer every D+1 cycles.
    drive(1'b0, 0, 1'b1, 'h1F);
    repeat (40) step();
    drive(1'b0, 0, 1'b0, 0);
    check("r031_count", 32'(count_1), 10);
    check("r031_sum", 32'(sum_1), 54);
    step();

    // Valid dropped right after sampling: sticky error, no transfer.
    drive(1'b1, 'h11, 1'b0, 0);
    step();
    drive(1'b0, 0, 1'b0, 0);
    repeat (5) step();
    check("r032_err", 32'(err_0), 1);
    check("r032_count", 32'(count_0), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("r032_clr_err", 32'(err_0), 0);

    // Both lanes at once.
    drive(1'b1, 3, 1'b1, 7);
    repeat (D) step();
    check("r033_ready0", 32'(i0.ready), 1);
    check("r033_ready1", 32'(i1.ready), 1);
    step();
    drive(1'b0, 0, 1'b0, 0);
    step();
    check("r033_sum0", 32'(sum_0), 3);
    check("r033_sum1", 32'(sum_1), 7);

    // Build sum_0 to 100, then clear in the same cycle as a transfer of 4.
    clr = 1'b1;
    step();
    clr = 1'b0;
    xfer0(31);
    xfer0(31);
    xfer0(31);
    xfer0(7);
    check("r035_pre", 32'(sum_0), 100);
    drive(1'b1, 4, 1'b0, 0);
    repeat (D) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    check("r035_sum", 32'(sum_0), 4);
    check("r035_count", 32'(count_0), 1);
    step();

    // Asynchronous reset mid-WAIT; valid stays high across the reset.
    drive(1'b1, 9, 1'b0, 0);
    step();
    step();
    #3;
    ASYNCRESETN = 1'b0;
    #1;
    model_reset();
    check("r034_ready", 32'(i0.ready), 0);
    check_stats();
    @(negedge CLK);
    ASYNCRESETN = 1'b1;
    cyc = 0;
    repeat (D) step();
    check("r034_restart", 32'(i0.ready), 1);
    step();
    check("r034_count", 32'(count_0), 1);
    drive(1'b0, 0, 1'b0, 0);
    step();

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 8, $urandom_range(0, (1 << W) - 1),
            $urandom_range(0, 9) < 8, $urandom_range(0, (1 << W) - 1));
      clr = ($urandom_range(0, 29) == 0);
      step();
    end
    clr = 1'b0;
    drive(1'b0, 0, 1'b0, 0);
    repeat (D + 2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
